// File: rtl/comp_serial_driver.sv
// Parallel-to-serial driver for a bit-serial magnitude comparator: clears it, shifts both
// operands out, latches the verdict. Optional verdict one-hot check: COMP_ONEHOT_CHECK_EN.
module comp_serial_driver #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ser_a,
    output logic             ser_b,
    output logic             cmp_reset,
    input  logic             gin,
    input  logic             ein,
    input  logic             lin,
    output logic             busy,
    output logic             done,
    output logic             res_g,
    output logic             res_e,
    output logic             res_l,
    output logic             err
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic             ser_a_q, ser_a_d;
    logic             ser_b_q, ser_b_d;
    logic             cmp_reset_q, cmp_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [2:0]       res_q, res_d;

    // Bit that goes on the wire next, and what remains of the operand afterwards.
    function automatic logic head(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] v);
        return MSB_FIRST ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        ser_a_d     = ser_a_q;
        ser_b_d     = ser_b_q;
        cmp_reset_d = cmp_reset_q;
        done_d      = 1'b0;
        res_d       = res_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d     = S_SHIFT;
                    cnt_d       = '0;
                    cmp_reset_d = 1'b0;
                    ser_a_d     = head(a_in);
                    ser_b_d     = head(b_in);
                    sh_a_d      = tail(a_in);
                    sh_b_d      = tail(b_in);
                end
            end
            S_SHIFT: begin
                if (cnt_q == LAST) begin
                    state_d = S_CAPTURE;
                    ser_a_d = 1'b0;
                    ser_b_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    ser_a_d = head(sh_a_q);
                    ser_b_d = head(sh_b_q);
                    sh_a_d  = tail(sh_a_q);
                    sh_b_d  = tail(sh_b_q);
                end
            end
            S_CAPTURE: begin
                res_d       = {gin, ein, lin};
                done_d      = 1'b1;
                cmp_reset_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d     = S_IDLE;
                cmp_reset_d = 1'b1;
                ser_a_d     = 1'b0;
                ser_b_d     = 1'b0;
            end
        endcase

        busy_d = (state_d == S_SHIFT) || (state_d == S_CAPTURE);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees
    // the pre-edge values of the others; shift registers are reset too, keeping aborts clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            ser_a_q     <= 1'b0;
            ser_b_q     <= 1'b0;
            cmp_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            ser_a_q     <= ser_a_d;
            ser_b_q     <= ser_b_d;
            cmp_reset_q <= cmp_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            res_q       <= res_d;
        end
    end

`ifdef COMP_ONEHOT_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == S_CAPTURE) begin
            err_d = !({gin, ein, lin} inside {3'b100, 3'b010, 3'b001});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == S_IDLE);
    assign ser_a     = ser_a_q;
    assign ser_b     = ser_b_q;
    assign cmp_reset = cmp_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign res_g     = res_q[2];
    assign res_e     = res_q[1];
    assign res_l     = res_q[0];

endmodule
